// File: rtl/mioc_od_parity_tx_pkg.sv
// Shared definitions for the open-drain parity transmitter: state encoding,
// line levels for framing bits, and a frame-length helper.
package mioc_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Bits per frame: start + data + parity + stop.
  function automatic int FRAME_BITS(input int data_w);
    return data_w + 3;
  endfunction

  // Line level the transmitter wants in a given state; idle is a released line.
  function automatic logic line_bit(input tx_state_e st, input logic data_bit,
                                    input logic par);
    logic lvl;
    lvl = STOP_LVL;
    case (st)
      S_START:  lvl = START_LVL;
      S_DATA:   lvl = data_bit;
      S_PARITY: lvl = par;
      default:  lvl = STOP_LVL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/mioc_od_parity_tx_if.sv
// Handshake and wired-line bundle between a word source and the open-drain
// transmitter. The transmitter side uses the slave modport.
interface mioc_od_parity_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              od_pd;
  logic              line_in;
  logic              busy;
  logic              done;
  logic              err_coll;

  modport master (
    output tx_data, tx_valid, line_in,
    input  tx_ready, od_pd, busy, done, err_coll
  );

  modport slave (
    input  tx_data, tx_valid, line_in,
    output tx_ready, od_pd, busy, done, err_coll
  );

endinterface

// File: rtl/mioc_od_parity_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYC-1 while enabled and flags the last
// cycle of each bit period.
module mioc_bit_timer #(
  parameter int BIT_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] cyc_cnt;

  assign bit_end = (cyc_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (clr) begin
      cyc_cnt <= '0;
    end else if (en) begin
      cyc_cnt <= bit_end ? '0 : cyc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mioc_od_parity_tx.sv
// Open-drain single-wire transmitter: START, DATA (LSB first), odd parity, STOP.
// Define MIOC_READBACK_EN to abort a frame when the sensed line disagrees.
module mioc_od_parity_tx
  import mioc_tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mioc_od_parity_tx_if.slave   bus
);

  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic [BCW-1:0]    cnt_q, cnt_d;
  logic              od_q, od_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              timer_clr, timer_en, bit_end;
  logic              accept, mismatch;

  assign bus.tx_ready = (state_q == S_IDLE) & bus.line_in;
  assign accept       = bus.tx_valid & bus.tx_ready;
  assign timer_en     = (state_q != S_IDLE);

  mioc_bit_timer #(.BIT_CYC(BIT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .bit_end (bit_end)
  );

`ifdef MIOC_READBACK_EN
  logic cur_bit;
  assign cur_bit  = line_bit(state_q, sh_q[0], par_q);
  // Sampled once per bit, at its last cycle, when the line has settled.
  assign mismatch = bit_end & (state_q != S_IDLE) & (bus.line_in ^ cur_bit);
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    sh_d      = sh_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    timer_clr = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_START;
          sh_d      = bus.tx_data;
          par_d     = ~^bus.tx_data;
          cnt_d     = '0;
          timer_clr = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (cnt_q == LAST_BIT) begin
            state_d = S_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BCW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A collision overrides whatever the bit sequencing decided.
    if (mismatch) begin
      state_d   = S_IDLE;
      sh_d      = sh_q;
      cnt_d     = '0;
      timer_clr = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end

    // Pull-down register tracks the next state so the line changes on the
    // same edge as the state.
    od_d   = (state_d != S_IDLE) & ~line_bit(state_d, sh_d[0], par_d);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      par_q  <= 1'b0;
      cnt_q  <= '0;
      od_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      par_q  <= par_d;
      cnt_q  <= cnt_d;
      od_q   <= od_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.od_pd    = od_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_coll = err_q;

endmodule

// File: tb/tb_mioc_od_parity_tx.sv
// Scoreboard bench for mioc_od_parity_tx (DATA_W=8, BIT_CYC=4): stimulus pushes
// expected per-bit od_pd patterns and frame endings, a monitor compares them.
module tb_mioc_od_parity_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ext_pd = 1'b1;

  always #5 clk = ~clk;

  mioc_od_parity_tx_if #(.DATA_W(8)) bus ();
  assign bus.line_in = ~bus.od_pd & ext_pd;

  mioc_od_parity_tx #(.DATA_W(8), .BIT_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {K_DONE, K_ERR, K_RST} kind_e;
  typedef struct {
    logic [10:0] od;       // bit k = expected od_pd during bit period k
    int          end_cyc;  // cycle after accept edge where the frame ends
    kind_e       kind;
    bit          b2b;      // must start in the same cycle the previous frame ended
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [10:0] od, input int end_cyc, input kind_e kind,
                      input bit b2b, input string name);
    exp_t e;
    e.od = od; e.end_cyc = end_cyc; e.kind = kind; e.b2b = b2b; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: tracks each accepted frame and compares against the queue head.
  initial begin : monitor
    exp_t cur;
    bit   active;
    int   k, neg, last_end, idx;
    logic [3:0] bi;
    active = 1'b0; k = 0; neg = 0; last_end = -10;
    forever begin
      @(negedge clk);
      neg++;
      if (!rst_n) begin
        if (active) begin
          check({cur.name, "_end_kind"}, int'(cur.kind), int'(K_RST));
          check({cur.name, "_rst_od"}, int'(bus.od_pd), 0);
          check({cur.name, "_rst_busy"}, int'(bus.busy), 0);
          active = 1'b0;
        end
      end else begin
        if (active) begin
          k++;
          if (k < cur.end_cyc) begin
            idx = (k - 1) / 4;
            if (idx > 10) idx = 10;
            bi = idx[3:0];
            check({cur.name, "_od"}, int'(bus.od_pd), int'(cur.od[bi]));
            check({cur.name, "_busy"}, int'(bus.busy), 1);
            check({cur.name, "_nopulse"}, int'({bus.done, bus.err_coll}), 0);
          end else begin
            check({cur.name, "_done"}, int'(bus.done), int'(cur.kind == K_DONE));
            check({cur.name, "_err"}, int'(bus.err_coll), int'(cur.kind == K_ERR));
            check({cur.name, "_end_od"}, int'(bus.od_pd), 0);
            check({cur.name, "_end_busy"}, int'(bus.busy), 0);
            active   = 1'b0;
            last_end = neg;
          end
        end else begin
          check("idle_nopulse", int'({bus.done, bus.err_coll}), 0);
        end
        if (!active && bus.tx_valid && bus.tx_ready) begin
          if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_accept: got accept, expected none");
          end else begin
            cur = q.pop_front();
            if (cur.b2b) check({cur.name, "_gap"}, neg - last_end, 0);
            active = 1'b1;
            k = 0;
          end
        end
      end
    end
  end

  // Offer a word and wait for the edge that accepts it; 'waited' = edges taken.
  task automatic send(input logic [7:0] d, input bit hold, output int waited);
    bit acc;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = bus.tx_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset state
    @(negedge clk);
    check("rst_ready", int'(bus.tx_ready), 1);
    check("rst_od", int'(bus.od_pd), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err_coll), 0);
    @(posedge clk); #1;

    // 2. 0xA5: od 1,0,1,0,1,1,0,1,0,0,0 ; done at cycle 45
    push(11'b000_1011_0101, 45, K_DONE, 1'b0, "a5");
    send(8'hA5, 1'b0, w);
    wait_idle();

    // 3. 0x00 then 0xFF back-to-back; data changed while busy must be ignored
    push(11'b001_1111_1111, 45, K_DONE, 1'b0, "x00");
    push(11'b000_0000_0001, 45, K_DONE, 1'b1, "xff");
    send(8'h00, 1'b1, w);
    bus.tx_data = 8'hFF;
    send(8'hFF, 1'b0, w);
    wait_idle();

    // 4. external pulldown during data bit 0 of 0x01 (intended 1)
`ifdef MIOC_READBACK_EN
    push(11'b011_1111_1101, 9, K_ERR, 1'b0, "coll");
`else
    push(11'b011_1111_1101, 45, K_DONE, 1'b0, "coll");
`endif
    send(8'h01, 1'b0, w);
    repeat (4) @(posedge clk);
    #1 ext_pd = 1'b0;
    repeat (4) @(posedge clk);
    #1 ext_pd = 1'b1;
    wait_idle();

    // 5. foreign driver holds line low while idle with a pending request
    ext_pd = 1'b0;
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_ready", int'(bus.tx_ready), 0);
      check("hold_od", int'(bus.od_pd), 0);
    end
    push(11'b001_1000_0111, 45, K_DONE, 1'b0, "x3c");
    @(posedge clk);
    #1 ext_pd = 1'b1;
    send(8'h3C, 1'b0, w);
    check("release_latency", w, 1);
    wait_idle();

    // 6. asynchronous reset mid-DATA
    push(11'b001_0100_1011, 1000, K_RST, 1'b0, "x5a");
    send(8'h5A, 1'b0, w);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_od", int'(bus.od_pd), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(bus.tx_ready), 1);
    repeat (50) @(posedge clk);
    #1;

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
